// File: rtl/seq_divider.sv
// Purpose  : unsigned N-bit restoring divider, one quotient bit per clock, feeding the ALU divide path.
// Latency  : finished rises N posedges after the last load (1 posedge for a zero divisor when DIV_ZERO_FAST_EN is defined).
// Backpress: none; start is a level request that reloads on every posedge it is high, aborting any division in flight.
//
// Ports:
//   CLK       in   1  system clock, all state changes on posedge
//   RESET_N   in   1  asynchronous active-low reset
//   a         in   N  dividend, sampled on a posedge with start=1
//   b         in   N  divisor, sampled on a posedge with start=1
//   start     in   1  level load request
//   result    out  N  quotient, valid while finished=1
//   high      out  N  remainder, valid while finished=1
//   finished  out  1  result/high hold the outcome of the last load
//   div_zero  out  1  the last loaded divisor was zero
//
// Build option: DIV_ZERO_FAST_EN -- when defined, a zero divisor completes one
// posedge after the load instead of running all N iterations.

module seq_divider #(
  parameter int N = 16
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         start,
  output logic [N-1:0] result,
  output logic [N-1:0] high,
  output logic         finished,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  dvd;   // dividend shifting out MSB-first, quotient bits shifting in at LSB
  logic [N-1:0]  dvs;   // divisor, constant for the whole division
  logic [N-1:0]  rem;   // partial remainder
  logic [CW-1:0] cnt;   // iterations completed since the last load

  logic [N:0]    trial;
  logic [N-1:0]  rem_nxt;
  logic [N-1:0]  dvd_nxt;

  // One restoring step. The partial remainder is widened by one bit so the
  // borrow out of the subtraction (trial[N]) says whether the divisor fits.
  always_comb begin
    trial   = {rem, dvd[N-1]} - {1'b0, dvs};
    rem_nxt = {rem[N-2:0], dvd[N-1]};
    dvd_nxt = {dvd[N-2:0], 1'b0};
    if (!trial[N]) begin
      rem_nxt = trial[N-1:0];
      dvd_nxt = {dvd[N-2:0], 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      result   <= '0;
      high     <= '0;
      finished <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      // A load wins in every state; result/high keep the previous outcome
      // until this new division completes.
      dvd      <= a;
      dvs      <= b;
      rem      <= '0;
      cnt      <= '0;
      finished <= 1'b0;
      div_zero <= (b == '0);
      state    <= BUSY;
    end else begin
      case (state)
        BUSY: begin
          if (FAST_DZ && div_zero) begin
            // dvd still holds the loaded dividend: no iteration has run yet.
            result   <= '1;
            high     <= dvd;
            finished <= 1'b1;
            state    <= DONE;
          end else begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt + CW'(1);
            if (cnt == LAST_ITER) begin
              result   <= dvd_nxt;
              high     <= rem_nxt;
              finished <= 1'b1;
              state    <= DONE;
            end
          end
        end
        IDLE:    state <= IDLE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
